fl_mc: RTL and testbench
========================

Name: fl_mc

Overview:
- Multi-port, reference-counted free list for the shared packet buffer. Successor to the single-port free list.
- Hands out block indices to the ingress writer. Each block carries a multicast reference count (number of egress ports that must read it).
- Each egress port releases its reference independently. A block returns to the pool only when its count reaches zero.
- Adds per-port free channels, refcounting, underflow error detection and a live free-block count.

Parameters:
- NUM_BLOCKS, 4096: number of buffer blocks; power of two.
- ADDR_W, $clog2(NUM_BLOCKS): block index width.
- NUM_FREE_PORTS, 4: independent release channels (one per egress port).
- REFCNT_W, 3: reference count width; maximum fan-out is 2**REFCNT_W-1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- alloc_req_i, in, 1: request one block.
- alloc_refcnt_i, in, REFCNT_W: initial reference count for the requested block.
- alloc_gnt_o, out, 1: one-cycle pulse; index is valid.
- alloc_block_idx_o, out, ADDR_W: granted index.
- free_req_i, in, NUM_FREE_PORTS: per-port release strobe.
- free_block_idx_i, in, NUM_FREE_PORTS*ADDR_W: per-port index; port p occupies bits [p*ADDR_W +: ADDR_W].
- free_count_o, out, ADDR_W+1: number of blocks currently free.
- err_o, out, 1: one-cycle pulse on an illegal request.

Behaviour:
- Reset:
  - alloc_gnt_o=0, alloc_block_idx_o=0, err_o=0, free_count_o=NUM_BLOCKS.
  - Fresh counter=0; recycle FIFO empty; all refcounts=0.
  - Reset asserted mid-operation discards all state in one cycle, with no INIT sweep.
- Storage:
  - Fresh counter serves never-used indices 0..NUM_BLOCKS-1 in ascending order.
  - Recycle FIFO has depth NUM_BLOCKS, ADDR_W-bit entries, circular pointers with a wrap bit, and up to NUM_FREE_PORTS pushes per cycle.
  - Refcount array: NUM_BLOCKS x REFCNT_W, held in flops.
- Alloc latency: request sampled at edge N. Grant and index are registered and visible after edge N, and held until edge N+1.
- Grant source priority:
  1. Bypass: the lowest-numbered port whose release drives a block to zero in the same cycle.
  2. FIFO head.
  3. Fresh counter (until it reaches NUM_BLOCKS).
  - If no source is available, alloc_gnt_o=0 and no error is raised.
- On grant, refcount[idx] is written to alloc_refcnt_i.
- alloc_refcnt_i==0 with alloc_req_i: no grant, err_o pulses, no state change.
- Release on port p:
  - refcount[idx] is decremented.
  - Several ports naming the same idx in one cycle decrement by the number of such ports.
  - If the result is 0, the block is pushed to the FIFO, unless it was consumed by the bypass path.
  - Pushes from several ports in one cycle are written in ascending port order.
- Release of a block whose refcount is 0, or whose decrement would underflow: that port's effect is dropped (count unchanged, no push) and err_o pulses. Other ports in the same cycle proceed normally.
- Release of an index granted in the same cycle is illegal and has undefined effect. Release from the cycle after the grant is legal.
- free_count_o is registered: next = current + blocks returned to the pool − (1 if granted).
- Invariant: free_count_o equals FIFO occupancy plus (NUM_BLOCKS − fresh counter). It never exceeds NUM_BLOCKS and never goes negative.
- FIFO overflow is unreachable by construction. The bench checks this with an assertion.

Test Plan:
- Reset, then NUM_BLOCKS allocs with refcnt=1 → grants idx 0..4095 in order, each one cycle after its request; free_count_o ends at 0. A further alloc → alloc_gnt_o=0, err_o=0.
- From empty, release idx 2048 on port 0, then alloc refcnt=1 → grant idx 2048; free_count_o goes 0→1→0.
- Multicast: alloc refcnt=3 receives idx k.
  - Release k on port 1 → block still held.
  - Same cycle, release k on ports 2 and 3 → refcount 0, free_count_o+1.
  - A fourth release of k → err_o pulses, free_count_o unchanged.
- From empty: alloc refcnt=1 in the same cycle as the final port-0 release of idx 1200 → grant idx 1200 via bypass; free_count_o stays 0.
- From empty, single-owner idx 5, 9, 12: release them on ports 3, 0, 2 in one cycle, then three allocs → grants 9, 12, 5 (ascending port order); free_count_o 3→0.
- Alloc with refcnt=0 → no grant, err_o pulses. Assert rst mid-stream → next alloc grants idx 0 and free_count_o=4096.

Source files
------------

// File: rtl/fl_mc.sv
// fl_mc: multi-port, reference-counted free list for the shared packet buffer.
// Blocks are handed out to the ingress writer with an initial fan-out count.
// Each egress port releases one reference at a time. A block rejoins the pool
// only when its last reference is released.
module fl_mc #(
    parameter int NUM_BLOCKS     = 4096,
    parameter int ADDR_W         = $clog2(NUM_BLOCKS),
    parameter int NUM_FREE_PORTS = 4,
    parameter int REFCNT_W       = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_req_i,
    input  logic [REFCNT_W-1:0]              alloc_refcnt_i,
    output logic                             alloc_gnt_o,
    output logic [ADDR_W-1:0]                alloc_block_idx_o,
    input  logic [NUM_FREE_PORTS-1:0]        free_req_i,
    input  logic [NUM_FREE_PORTS*ADDR_W-1:0] free_block_idx_i,
    output logic [ADDR_W:0]                  free_count_o,
    output logic                             err_o
);

    localparam logic [ADDR_W:0]   BLOCKS_C = (ADDR_W+1)'(NUM_BLOCKS);
    localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W+1)'(1);
    localparam logic [REFCNT_W-1:0] RC_ONE = REFCNT_W'(1);

    // Architectural state
    logic [REFCNT_W-1:0] refCnt_q  [NUM_BLOCKS];
    logic [ADDR_W-1:0]   fifoMem_q [NUM_BLOCKS];
    logic [ADDR_W:0]     wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]     rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]     freshCnt_q, freshCnt_d;
    logic [ADDR_W:0]     freeCount_q, freeCount_d;
    logic                allocGnt_q;
    logic [ADDR_W-1:0]   allocIdx_q;
    logic                err_q, err_d;

    // Per-port release decode
    logic [ADDR_W-1:0]         relIdx    [NUM_FREE_PORTS];
    logic [REFCNT_W-1:0]       relNewCnt [NUM_FREE_PORTS];
    logic [ADDR_W-1:0]         pushAddr  [NUM_FREE_PORTS];
    logic [NUM_FREE_PORTS-1:0] relOk, relErr, relZero, relPush;
    logic [ADDR_W:0]           numPush;
    logic                      bypassHit;
    logic [ADDR_W-1:0]         bypassIdx;

    // Grant selection
    logic                      allocLegal;
    logic                      fifoEmpty, freshAvail;
    logic                      grant, popFifo, takeFresh;
    logic [ADDR_W-1:0]         grantIdx;

    assign allocLegal = alloc_req_i && (alloc_refcnt_i != '0);

    // Resolve every release port in ascending order: earlier accepted ports
    // naming the same block lower the count seen by later ones, so over-release
    // is caught per port. The lowest zeroing port feeds the bypass; the rest
    // are packed into consecutive FIFO slots.
    always_comb begin
        logic [REFCNT_W-1:0] cur;
        logic [ADDR_W:0]     runOff;
        cur       = '0;
        runOff    = '0;
        relOk     = '0;
        relErr    = '0;
        relZero   = '0;
        relPush   = '0;
        bypassHit = 1'b0;
        bypassIdx = '0;
        for (int p = 0; p < NUM_FREE_PORTS; p++) begin
            relIdx[p]    = free_block_idx_i[p*ADDR_W +: ADDR_W];
            relNewCnt[p] = '0;
            pushAddr[p]  = '0;
        end
        for (int p = 0; p < NUM_FREE_PORTS; p++) begin
            cur = refCnt_q[relIdx[p]];
            for (int q = 0; q < p; q++) begin
                if (relOk[q] && (relIdx[q] == relIdx[p])) begin
                    cur = cur - RC_ONE;
                end
            end
            if (free_req_i[p]) begin
                if (cur == '0) begin
                    relErr[p] = 1'b1;
                end else begin
                    relOk[p]     = 1'b1;
                    relNewCnt[p] = cur - RC_ONE;
                    relZero[p]   = (cur == RC_ONE);
                end
            end
        end
        for (int p = 0; p < NUM_FREE_PORTS; p++) begin
            if (relZero[p] && allocLegal && !bypassHit) begin
                bypassHit = 1'b1;
                bypassIdx = relIdx[p];
            end else if (relZero[p]) begin
                relPush[p]  = 1'b1;
                pushAddr[p] = wrPtr_q[ADDR_W-1:0] + runOff[ADDR_W-1:0];
                runOff      = runOff + ONE_C;
            end
        end
        numPush = runOff;
    end

    // Pick the grant source (bypass, then FIFO head, then fresh) and form the
    // next pointer, counter and status values. The FIFO can never overflow:
    // every push is a block that was previously granted and is not in the pool.
    always_comb begin
        fifoEmpty  = (wrPtr_q == rdPtr_q);
        freshAvail = (freshCnt_q != BLOCKS_C);
        grant      = 1'b0;
        popFifo    = 1'b0;
        takeFresh  = 1'b0;
        grantIdx   = '0;
        if (allocLegal) begin
            if (bypassHit) begin
                grant    = 1'b1;
                grantIdx = bypassIdx;
            end else if (!fifoEmpty) begin
                grant    = 1'b1;
                popFifo  = 1'b1;
                grantIdx = fifoMem_q[rdPtr_q[ADDR_W-1:0]];
            end else if (freshAvail) begin
                grant     = 1'b1;
                takeFresh = 1'b1;
                grantIdx  = freshCnt_q[ADDR_W-1:0];
            end
        end
        wrPtr_d     = wrPtr_q + numPush;
        rdPtr_d     = rdPtr_q + {{ADDR_W{1'b0}}, popFifo};
        freshCnt_d  = freshCnt_q + {{ADDR_W{1'b0}}, takeFresh};
        freeCount_d = freeCount_q + numPush + {{ADDR_W{1'b0}}, bypassHit}
                      - {{ADDR_W{1'b0}}, grant};
        err_d       = (alloc_req_i && (alloc_refcnt_i == '0)) || (|relErr);
    end

    // Register outputs, pointers and reference counts; a grant's new count
    // overrides the decrement of a block recycled through the bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            allocGnt_q  <= 1'b0;
            allocIdx_q  <= '0;
            err_q       <= 1'b0;
            freeCount_q <= BLOCKS_C;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            freshCnt_q  <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                refCnt_q[i] <= '0;
            end
        end else begin
            allocGnt_q  <= grant;
            if (grant) begin
                allocIdx_q <= grantIdx;
            end
            err_q       <= err_d;
            freeCount_q <= freeCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            freshCnt_q  <= freshCnt_d;
            for (int p = 0; p < NUM_FREE_PORTS; p++) begin
                if (relOk[p]) begin
                    refCnt_q[relIdx[p]] <= relNewCnt[p];
                end
            end
            if (grant) begin
                refCnt_q[grantIdx] <= alloc_refcnt_i;
            end
        end
    end

    // Write recycled blocks into the FIFO in ascending port order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NUM_FREE_PORTS; p++) begin
                if (relPush[p]) begin
                    fifoMem_q[pushAddr[p]] <= relIdx[p];
                end
            end
        end
    end

    assign alloc_gnt_o       = allocGnt_q;
    assign alloc_block_idx_o = allocIdx_q;
    assign free_count_o      = freeCount_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_fl_mc.sv
// tb_fl_mc: scoreboard bench for fl_mc. The driver applies one stimulus per
// cycle, steps a pool/queue reference model and queues the expected response;
// the monitor pops and compares after each rising edge.
module tb_fl_mc;

    localparam int N  = 4096;
    localparam int AW = 12;
    localparam int NP = 4;
    localparam int RW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_req_i = 1'b0;
    logic [RW-1:0]    alloc_refcnt_i = '0;
    logic             alloc_gnt_o;
    logic [AW-1:0]    alloc_block_idx_o;
    logic [NP-1:0]    free_req_i = '0;
    logic [NP*AW-1:0] free_block_idx_i = '0;
    logic [AW:0]      free_count_o;
    logic             err_o;

    typedef struct {
        logic          gnt;
        logic [AW-1:0] idx;
        logic          err;
        logic [AW:0]   fc;
    } expT;

    expT expQ[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference model: per-block counts, recycle queue, fresh index
    int mRef [N];
    int mFifo[$];
    int mFresh = 0;
    int heldQ[$];

    // Free-running clock
    always #5 clk = ~clk;

    fl_mc #(
        .NUM_BLOCKS(N), .ADDR_W(AW), .NUM_FREE_PORTS(NP), .REFCNT_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_req_i(alloc_req_i),
        .alloc_refcnt_i(alloc_refcnt_i),
        .alloc_gnt_o(alloc_gnt_o),
        .alloc_block_idx_o(alloc_block_idx_o),
        .free_req_i(free_req_i),
        .free_block_idx_i(free_block_idx_i),
        .free_count_o(free_count_o),
        .err_o(err_o)
    );

    function automatic logic [NP*AW-1:0] packIdx(input int a, input int b, input int c, input int d);
        return {AW'(d), AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input expT e);
        compareField("alloc_gnt", 32'(alloc_gnt_o), 32'(e.gnt));
        if (e.gnt) compareField("alloc_idx", 32'(alloc_block_idx_o), 32'(e.idx));
        compareField("err", 32'(err_o), 32'(e.err));
        compareField("free_count", 32'(free_count_o), 32'(e.fc));
        vectors++;
        if (32'(free_count_o) > N) begin
            miscompares++;
            $display("[TB] FAIL free_count_bound: got %0d, limit %0d", free_count_o, N);
        end
    endtask

    // One cycle of pool behaviour: releases in port order, then the grant
    // (newly zeroed blocks first, then recycled, then fresh), then the
    // remaining zeroed blocks join the recycle queue.
    task automatic modelStep(input logic r, input logic req, input logic [RW-1:0] rc,
                             input logic [NP-1:0] fr, input logic [NP*AW-1:0] flat,
                             output expT e);
        int zl[$];
        int id;
        int g;
        bit got;
        e.gnt = 1'b0; e.idx = '0; e.err = 1'b0; e.fc = '0;
        if (r) begin
            for (int i = 0; i < N; i++) mRef[i] = 0;
            mFifo.delete();
            heldQ.delete();
            mFresh = 0;
            e.fc = (AW+1)'(N);
            return;
        end
        for (int p = 0; p < NP; p++) begin
            if (fr[p]) begin
                id = int'(flat[p*AW +: AW]);
                if (mRef[id] == 0) e.err = 1'b1;
                else begin
                    mRef[id]--;
                    if (mRef[id] == 0) zl.push_back(id);
                end
            end
        end
        if (req) begin
            got = 0;
            g = 0;
            if (rc == 0) e.err = 1'b1;
            else if (zl.size() > 0) begin g = zl.pop_front(); got = 1; end
            else if (mFifo.size() > 0) begin g = mFifo.pop_front(); got = 1; end
            else if (mFresh < N) begin g = mFresh; mFresh++; got = 1; end
            if (got) begin
                e.gnt = 1'b1;
                e.idx = AW'(g);
                mRef[g] = int'(rc);
                heldQ.push_back(g);
            end
        end
        foreach (zl[i]) mFifo.push_back(zl[i]);
        assert (mFifo.size() <= N) else $error("[TB] FAIL fifo_overflow: occupancy %0d", mFifo.size());
        e.fc = (AW+1)'(mFifo.size() + N - mFresh);
    endtask

    // Pick a recently granted block that still holds references, or -1.
    function automatic int pickHeld();
        int j;
        int lo;
        for (int t = 0; t < 16; t++) begin
            if (heldQ.size() == 0) return -1;
            lo = (heldQ.size() > 8) ? heldQ.size() - 8 : 0;
            j = $urandom_range(lo, heldQ.size() - 1);
            if (mRef[heldQ[j]] > 0) return heldQ[j];
            heldQ.delete(j);
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic r, input logic req, input logic [RW-1:0] rc,
                                 input logic [NP-1:0] fr, input logic [NP*AW-1:0] flat);
        expT e;
        @(negedge clk);
        rst = r;
        alloc_req_i = req;
        alloc_refcnt_i = rc;
        free_req_i = fr;
        free_block_idx_i = flat;
        modelStep(r, req, rc, fr, flat, e);
        expQ.push_back(e);
    endtask

    // Monitor: compare each queued expectation just after the edge it covers
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic
    initial begin
        logic          req;
        logic [RW-1:0] rc;
        logic [NP-1:0] fr;
        logic [NP*AW-1:0] flat;
        int id;

        $display("[TB] start");
        repeat (2) applyStimulus(1'b1, 1'b0, '0, '0, '0);

        repeat (N) applyStimulus(1'b0, 1'b1, 3'd1, '0, '0);
        applyStimulus(1'b0, 1'b1, 3'd1, '0, '0);

        applyStimulus(1'b0, 1'b0, '0, 4'b0001, packIdx(2048, 0, 0, 0));
        applyStimulus(1'b0, 1'b1, 3'd1, '0, '0);

        applyStimulus(1'b0, 1'b0, '0, 4'b0001, packIdx(100, 0, 0, 0));
        applyStimulus(1'b0, 1'b1, 3'd3, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, 4'b0010, packIdx(0, 100, 0, 0));
        applyStimulus(1'b0, 1'b0, '0, 4'b1100, packIdx(0, 0, 100, 100));
        applyStimulus(1'b0, 1'b0, '0, 4'b0001, packIdx(100, 0, 0, 0));
        applyStimulus(1'b0, 1'b1, 3'd1, '0, '0);

        applyStimulus(1'b0, 1'b1, 3'd1, 4'b0001, packIdx(1200, 0, 0, 0));

        applyStimulus(1'b0, 1'b0, '0, 4'b1101, packIdx(9, 0, 12, 5));
        repeat (3) applyStimulus(1'b0, 1'b1, 3'd1, '0, '0);

        applyStimulus(1'b0, 1'b1, 3'd0, '0, '0);
        applyStimulus(1'b0, 1'b1, 3'd2, 4'b0011, packIdx(300, 301, 0, 0));
        applyStimulus(1'b1, 1'b1, 3'd1, '0, '0);
        applyStimulus(1'b0, 1'b1, 3'd1, '0, '0);

        for (int c = 0; c < 3000; c++) begin
            req  = ($urandom_range(0, 99) < 45);
            rc   = ($urandom_range(0, 19) == 0) ? 3'd0 : RW'($urandom_range(1, 7));
            fr   = '0;
            flat = '0;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 99) < 35) begin
                    id = pickHeld();
                    if (id >= 0) begin
                        fr[p] = 1'b1;
                        flat[p*AW +: AW] = AW'(id);
                    end
                end
            end
            if (!req && $urandom_range(0, 9) == 0) begin
                fr[0] = 1'b1;
                flat[0 +: AW] = AW'($urandom_range(0, N - 1));
            end
            if (c == 1500) applyStimulus(1'b1, 1'b0, '0, '0, '0);
            applyStimulus(1'b0, req, rc, fr, flat);
        end

        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
